// File: rtl/bot_port_if.sv
// rtl/bot_port_if.sv - KCPSM6 I/O responder for the Rojobot register set.
// Shadowed bot status reads, motctl write-back, update interrupt and overrun counter.
module bot_port_if #(
  parameter bit         ALT_EN   = 1'b1,
  parameter logic [7:0] OVR_PORT = 8'h08
) (
  input  logic       sysclk,
  input  logic       sysreset,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] io_data_in,
  output logic [7:0] io_data_out,
  output logic       interrupt,
  input  logic       interrupt_ack,
  input  logic       upd_sysregs,
  input  logic [7:0] locx,
  input  logic [7:0] locy,
  input  logic [7:0] botinfo,
  input  logic [7:0] sensors,
  input  logic [7:0] lmdist,
  input  logic [7:0] rmdist,
  output logic [7:0] motctl,
  output logic       motctl_wr
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [1:0] rst_sync;
  logic       rst_n;
  logic [0:0] state;
  logic [7:0] sh_locx, sh_locy, sh_botinfo, sh_sensors, sh_lmdist, sh_rmdist;
  logic [7:0] ovr_cnt;
  logic [7:0] rd_data;
  logic       ovr_inc, ovr_clr, mot_hit;

  // Assert follows sysreset at once; release waits two sysclk edges.
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  function automatic logic hit(input logic [7:0] addr, input logic [7:0] base);
    return (addr == base) || (ALT_EN && (addr == (base | 8'h10)));
  endfunction

  assign mot_hit = hit(port_id, 8'h09);
  assign ovr_inc = upd_sysregs && (state == PEND) && !interrupt_ack;
  assign ovr_clr = read_strobe && hit(port_id, OVR_PORT);

  always_comb begin
    rd_data = 8'h00;
    if      (mot_hit)                rd_data = motctl;
    else if (hit(port_id, 8'h0A))    rd_data = sh_locx;
    else if (hit(port_id, 8'h0B))    rd_data = sh_locy;
    else if (hit(port_id, 8'h0C))    rd_data = sh_botinfo;
    else if (hit(port_id, 8'h0D))    rd_data = sh_sensors;
    else if (hit(port_id, 8'h0E))    rd_data = sh_lmdist;
    else if (hit(port_id, 8'h0F))    rd_data = sh_rmdist;
    else if (hit(port_id, OVR_PORT)) rd_data = ovr_cnt;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      io_data_out <= 8'h00;
      motctl      <= 8'h00;
      motctl_wr   <= 1'b0;
      state       <= IDLE;
      ovr_cnt     <= 8'h00;
      sh_locx     <= 8'h00;
      sh_locy     <= 8'h00;
      sh_botinfo  <= 8'h00;
      sh_sensors  <= 8'h00;
      sh_lmdist   <= 8'h00;
      sh_rmdist   <= 8'h00;
    end else begin
      io_data_out <= rd_data;
      motctl_wr   <= write_strobe && mot_hit;
      if (write_strobe && mot_hit) motctl <= io_data_in;

      if (upd_sysregs) begin
        sh_locx    <= locx;
        sh_locy    <= locy;
        sh_botinfo <= botinfo;
        sh_sensors <= sensors;
        sh_lmdist  <= lmdist;
        sh_rmdist  <= rmdist;
      end

      // A fresh update outranks a same-cycle ack so no event is lost.
      if (upd_sysregs)        state <= PEND;
      else if (interrupt_ack) state <= IDLE;

      if (ovr_clr)                         ovr_cnt <= {7'b0, ovr_inc};
      else if (ovr_inc && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'h01;
    end
  end

  assign interrupt = (state == PEND);

endmodule

// File: tb/tb_bot_port_if.sv
// tb/tb_bot_port_if.sv - self-checking bench for bot_port_if, both address maps.
module tb_bot_port_if;

  logic       clk = 1'b0;
  logic       sysreset;
  logic [7:0] port_id, io_data_in;
  logic       write_strobe, read_strobe, interrupt_ack, upd_sysregs;
  logic [7:0] locx, locy, botinfo, sensors, lmdist, rmdist;
  logic [7:0] out1, out0, mot1, mot0;
  logic       int1, int0, mwr1, mwr0;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bot_port_if #(.ALT_EN(1'b1), .OVR_PORT(8'h08)) dut1 (
    .sysclk(clk), .sysreset(sysreset), .port_id(port_id), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .io_data_in(io_data_in), .io_data_out(out1),
    .interrupt(int1), .interrupt_ack(interrupt_ack), .upd_sysregs(upd_sysregs),
    .locx(locx), .locy(locy), .botinfo(botinfo), .sensors(sensors), .lmdist(lmdist),
    .rmdist(rmdist), .motctl(mot1), .motctl_wr(mwr1));

  bot_port_if #(.ALT_EN(1'b0), .OVR_PORT(8'h08)) dut0 (
    .sysclk(clk), .sysreset(sysreset), .port_id(port_id), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .io_data_in(io_data_in), .io_data_out(out0),
    .interrupt(int0), .interrupt_ack(interrupt_ack), .upd_sysregs(upd_sysregs),
    .locx(locx), .locy(locy), .botinfo(botinfo), .sensors(sensors), .lmdist(lmdist),
    .rmdist(rmdist), .motctl(mot0), .motctl_wr(mwr0));

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: index 0 is the ALT_EN=0 instance, index 1 the ALT_EN=1 instance.
  logic [7:0] m_sh[6];
  logic [7:0] m_mot[2], m_ovr[2], m_out[2];
  logic       m_mwr[2];
  logic       m_pend, m_inc, m_clr;
  int         rel_cnt = 0;

  function automatic logic mhit(input int k, input logic [7:0] a, input logic [7:0] base);
    return (a == base) || (k == 1 && a == (base | 8'h10));
  endfunction

  function automatic logic [7:0] mread(input int k, input logic [7:0] a);
    if (mhit(k, a, 8'h09)) return m_mot[k];
    for (int i = 0; i < 6; i++)
      if (mhit(k, a, 8'(8'h0A + i))) return m_sh[i];
    if (mhit(k, a, 8'h08)) return m_ovr[k];
    return 8'h00;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 6; i++) m_sh[i] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      m_mot[k] = 8'h00; m_ovr[k] = 8'h00; m_out[k] = 8'h00; m_mwr[k] = 1'b0;
    end
    m_pend = 1'b0;
  endtask

  initial m_clear();

  always @(negedge sysreset) begin
    m_clear();
    rel_cnt = 0;
  end

  always @(posedge clk) begin
    if (!sysreset) begin
      m_clear();
      rel_cnt = 0;
    end else if (rel_cnt < 2) begin
      rel_cnt++;
    end else begin
      for (int k = 0; k < 2; k++) m_out[k] = mread(k, port_id);
      m_inc = upd_sysregs && m_pend && !interrupt_ack;
      for (int k = 0; k < 2; k++) begin
        m_mwr[k] = write_strobe && mhit(k, port_id, 8'h09);
        if (m_mwr[k]) m_mot[k] = io_data_in;
        m_clr = read_strobe && mhit(k, port_id, 8'h08);
        if (m_clr)                          m_ovr[k] = m_inc ? 8'h01 : 8'h00;
        else if (m_inc && m_ovr[k] < 8'hFF) m_ovr[k] = m_ovr[k] + 8'h01;
      end
      if (upd_sysregs) begin
        m_pend = 1'b1;
        m_sh[0] = locx; m_sh[1] = locy; m_sh[2] = botinfo;
        m_sh[3] = sensors; m_sh[4] = lmdist; m_sh[5] = rmdist;
      end else if (interrupt_ack) begin
        m_pend = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("io_data_out_alt1", out1, m_out[1]);
      chk("io_data_out_alt0", out0, m_out[0]);
      chk("motctl_alt1", mot1, m_mot[1]);
      chk("motctl_alt0", mot0, m_mot[0]);
      chk("motctl_wr_alt1", {7'b0, mwr1}, {7'b0, m_mwr[1]});
      chk("motctl_wr_alt0", {7'b0, mwr0}, {7'b0, m_mwr[0]});
      chk("interrupt_alt1", {7'b0, int1}, {7'b0, m_pend});
      chk("interrupt_alt0", {7'b0, int0}, {7'b0, m_pend});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_live(input logic [7:0] v);
    locx = v; locy = v; botinfo = v; sensors = v; lmdist = v; rmdist = v;
  endtask

  logic [7:0] snap[6];

  initial begin
    snap = '{8'h3C, 8'h5A, 8'h81, 8'h12, 8'h07, 8'h09};
    sysreset = 1'b0;
    port_id = 8'h00; io_data_in = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0;
    interrupt_ack = 1'b0; upd_sysregs = 1'b0; set_live(8'h00);

    // reset with toggling inputs
    repeat (4) begin
      port_id = 8'($urandom); io_data_in = 8'($urandom);
      write_strobe = 1'($urandom); read_strobe = 1'($urandom);
      interrupt_ack = 1'($urandom); upd_sysregs = 1'($urandom);
      set_live(8'($urandom));
      tick(1);
      chk_en = 1'b1;
      chk("rst_io_data_out", out1, 8'h00);
      chk("rst_interrupt", {7'b0, int1}, 8'h00);
    end
    port_id = 8'h00; io_data_in = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0;
    interrupt_ack = 1'b0; upd_sysregs = 1'b0; set_live(8'h00);
    sysreset = 1'b1;
    tick(3);
    for (int i = 0; i < 6; i++) begin
      port_id = 8'(8'h0A + i);
      tick(1);
      chk("rst_shadow", out1, 8'h00);
    end

    // snapshot on both maps
    locx = 8'h3C; locy = 8'h5A; botinfo = 8'h81; sensors = 8'h12; lmdist = 8'h07; rmdist = 8'h09;
    upd_sysregs = 1'b1; tick(1); upd_sysregs = 1'b0;
    set_live(8'hFF);
    for (int i = 0; i < 6; i++) begin
      port_id = 8'(8'h0A + i);
      tick(1);
      chk("snap_base_alt1", out1, snap[i]);
      chk("snap_base_alt0", out0, snap[i]);
    end
    for (int i = 0; i < 6; i++) begin
      port_id = 8'(8'h1A + i);
      tick(1);
      chk("snap_alt_map", out1, snap[i]);
      chk("snap_alt_off", out0, 8'h00);
    end
    locx = 8'h11; port_id = 8'h0A; upd_sysregs = 1'b1;
    tick(1); upd_sysregs = 1'b0;
    chk("snap_same_cycle", out1, 8'h3C);
    tick(1);
    chk("snap_after", out1, 8'h11);

    // motctl
    port_id = 8'h09; io_data_in = 8'hA5; write_strobe = 1'b1;
    tick(1); write_strobe = 1'b0;
    chk("motctl_val", mot1, 8'hA5);
    chk("motctl_wr_pulse", {7'b0, mwr1}, 8'h01);
    tick(1);
    chk("motctl_wr_single", {7'b0, mwr1}, 8'h00);
    chk("motctl_read", out1, 8'hA5);
    port_id = 8'h30; io_data_in = 8'h33; write_strobe = 1'b1;
    tick(1); write_strobe = 1'b0;
    chk("motctl_other_port", mot1, 8'hA5);

    // interrupt handshake
    port_id = 8'h00; interrupt_ack = 1'b1; tick(1); interrupt_ack = 1'b0;
    chk("int_acked", {7'b0, int1}, 8'h00);
    upd_sysregs = 1'b1; tick(1); upd_sysregs = 1'b0;
    chk("int_rise", {7'b0, int1}, 8'h01);
    interrupt_ack = 1'b1; tick(1); interrupt_ack = 1'b0;
    chk("int_fall", {7'b0, int1}, 8'h00);
    upd_sysregs = 1'b1; tick(1);
    interrupt_ack = 1'b1; tick(1); upd_sysregs = 1'b0; interrupt_ack = 1'b0;
    chk("int_upd_and_ack", {7'b0, int1}, 8'h01);
    tick(1);
    chk("int_held", {7'b0, int1}, 8'h01);

    // overrun counter
    interrupt_ack = 1'b1; tick(1); interrupt_ack = 1'b0;
    port_id = 8'h08; read_strobe = 1'b1; tick(1); read_strobe = 1'b0; port_id = 8'h00;
    repeat (3) begin
      upd_sysregs = 1'b1; tick(1); upd_sysregs = 1'b0; tick(1);
    end
    port_id = 8'h08; read_strobe = 1'b1; tick(1); read_strobe = 1'b0;
    chk("ovr_three", out1, 8'h02);
    tick(1);
    chk("ovr_cleared", out1, 8'h00);
    port_id = 8'h00; upd_sysregs = 1'b1; tick(300); upd_sysregs = 1'b0;
    port_id = 8'h18; read_strobe = 1'b1; tick(1); read_strobe = 1'b0;
    chk("ovr_saturate", out1, 8'hFF);
    port_id = 8'h08; upd_sysregs = 1'b1; read_strobe = 1'b1;
    tick(1); upd_sysregs = 1'b0; read_strobe = 1'b0;
    tick(1);
    chk("ovr_inc_and_clear", out1, 8'h01);
    read_strobe = 1'b1; tick(1); read_strobe = 1'b0; port_id = 8'h00;

    // mid-operation reset
    port_id = 8'h19; io_data_in = 8'h5F; write_strobe = 1'b1;
    tick(1); write_strobe = 1'b0; port_id = 8'h00;
    upd_sysregs = 1'b1; tick(1); upd_sysregs = 1'b0;
    chk("pre_rst_motctl", mot1, 8'h5F);
    chk("pre_rst_int", {7'b0, int1}, 8'h01);
    #1 sysreset = 1'b0;
    #1;
    chk("async_rst_int", {7'b0, int1}, 8'h00);
    chk("async_rst_motctl", mot1, 8'h00);
    tick(2);
    sysreset = 1'b1;
    repeat (5) begin
      tick(1);
      chk("post_rst_no_wr", {7'b0, mwr1}, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
